// File: rtl/mux_stream_rr.sv
// N-channel registered stream multiplexer: manual select or fair round-robin
// arbitration, feeding one output register with full-throughput backpressure.
module mux_stream_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 1,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic [SELW-1:0]    out_ch,
  input  logic               out_ready
);

  logic [WIDTH-1:0] data_p0;
  logic             vld_p0;
  logic [SELW-1:0]  ch_p0;
  logic [SELW-1:0]  last_ch;
  logic             load_en;
  logic             grant_valid;
  logic             in_xfer;
  logic [SELW-1:0]  grant;
  logic [WIDTH-1:0] grant_data;
  logic             sel_unused;

  // Index `step` positions after `base`, modulo N, so non-power-of-two N never
  // produces an out-of-range channel.
  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base,
                                               input int step);
    int sum;
    sum = (int'(base) + step) % N;
    return SELW'(sum);
  endfunction

  // sel only matters in manual mode; folding it here keeps it referenced.
  assign sel_unused = ^sel;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    if (MODE == 0) begin
      if (int'(sel) < N) begin
        grant_valid = in_valid[sel];
        grant       = sel;
      end
    end else begin
      // Search last+1 .. last+N; the final candidate is `last` itself.
      for (int i = 1; i <= N; i++) begin
        if (!grant_valid && in_valid[wrap_idx(last_ch, i)]) begin
          grant_valid = 1'b1;
          grant       = wrap_idx(last_ch, i);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant == SELW'(k)) grant_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign load_en = !vld_p0 || out_ready;
  assign in_xfer = load_en && grant_valid && !rst;

  always_comb begin
    in_ready = '0;
    if (in_xfer) in_ready[grant] = 1'b1;
  end

  // Stage p0: output register; a new beat may replace one leaving this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      ch_p0   <= '0;
      last_ch <= SELW'(N - 1);
    end else if (in_xfer) begin
      vld_p0  <= 1'b1;
      data_p0 <= grant_data;
      ch_p0   <= grant;
      last_ch <= grant;
    end else if (vld_p0 && out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign out_data  = data_p0;
  assign out_valid = vld_p0;
  assign out_ch    = ch_p0;

endmodule
